// File: rtl/mem_access.sv
// MIPS MEM stage: loads/stores over a req/ack bus, big-endian lane handling.
// Latency: load/store holds the stage >=2 cycles (issue cycle + bus cycles to ack); non-memory ops 0.
// Backpressure: stallreq while a transfer is outstanding; ack under a foreign stall parks data in HOLD.
// Ports: clk/rst (sync, active-high); stall/flush from control; ex_* from EX/MEM register;
//        mem_* to mem_wb; stallreq/addr_err to control; bus_* registered request side, bus_rdata/bus_ack from slave.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic        ex_cp0_reg_we,
    input  logic [4:0]  ex_cp0_reg_write_addr,
    input  logic [31:0] ex_cp0_reg_data,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_cp0_reg_we,
    output logic [4:0]  mem_cp0_reg_write_addr,
    output logic [31:0] mem_cp0_reg_data,
    output logic        stallreq,
    output logic        addr_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD, S_DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] cap_q;
    logic [1:0]  off;
    logic        is_load, is_store, misaligned, valid_op;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic        issue, capture, use_cap, kill, stallreq_c;
    logic [31:0] src;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;

    assign off      = ex_mem_addr[1:0];
    assign valid_op = (is_load | is_store) & ~misaligned & ~flush;

    // Op decode, alignment check and store lane steering.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel_c      = 4'b0000;
        wdata_c    = ex_reg2;
        case (ex_op)
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
                sel_c   = 4'b1000 >> off;
            end
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                misaligned = off[0];
                sel_c      = off[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = (off != 2'b00);
                sel_c      = 4'b1111;
            end
            OP_SB: begin
                is_store = 1'b1;
                sel_c    = 4'b1000 >> off;
                wdata_c  = {4{ex_reg2[7:0]}};
            end
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = off[0];
                sel_c      = off[1] ? 4'b0011 : 4'b1100;
                wdata_c    = {2{ex_reg2[15:0]}};
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = (off != 2'b00);
                sel_c      = 4'b1111;
            end
            default: ;
        endcase
    end

    // Big-endian load extraction; HOLD reads the captured word since the bus has moved on.
    always_comb begin
        src = use_cap ? cap_q : bus_rdata;
        case (off)
            2'd0:    byte_v = src[31:24];
            2'd1:    byte_v = src[23:16];
            2'd2:    byte_v = src[15:8];
            default: byte_v = src[7:0];
        endcase
        half_v = off[1] ? src[15:0] : src[31:16];
        case (ex_op)
            OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_val = {24'h000000, byte_v};
            OP_LH:   load_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_val = {16'h0000, half_v};
            default: load_val = src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_sel   <= 4'h0;
            bus_wdata <= 32'h0;
            cap_q     <= 32'h0;
        end else begin
            state <= state_nx;
            if (issue) begin
                bus_req   <= 1'b1;
                bus_we    <= is_store;
                bus_addr  <= {ex_mem_addr[31:2], 2'b00};
                bus_sel   <= sel_c;
                bus_wdata <= wdata_c;
            end else if (bus_req && bus_ack) begin
                bus_req <= 1'b0;
                bus_we  <= 1'b0;
            end
            if (capture) begin
                cap_q <= bus_rdata;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        capture    = 1'b0;
        use_cap    = 1'b0;
        kill       = 1'b0;
        stallreq_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_op) begin
                    issue      = 1'b1;
                    stallreq_c = 1'b1;
                    state_nx   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    // Bus cannot abort: keep the request up in DRAIN unless the ack is already here.
                    kill     = 1'b1;
                    state_nx = bus_ack ? S_IDLE : S_DRAIN;
                end else if (bus_ack) begin
                    if (stall != 6'b000000) begin
                        capture  = 1'b1;
                        state_nx = S_HOLD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    stallreq_c = 1'b1;
                end
            end
            S_HOLD: begin
                use_cap = 1'b1;
                if (flush) begin
                    kill     = 1'b1;
                    state_nx = S_DRAIN;
                end else if (stall == 6'b000000) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                // DRAIN: outstanding request (if any) completes and its data is dropped.
                kill       = 1'b1;
                stallreq_c = valid_op;
                if (!bus_req || bus_ack) begin
                    state_nx = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        mem_wd                 = 5'h0;
        mem_wreg               = 1'b0;
        mem_wdata              = 32'h0;
        mem_cp0_reg_we         = 1'b0;
        mem_cp0_reg_write_addr = 5'h0;
        mem_cp0_reg_data       = 32'h0;
        stallreq               = 1'b0;
        addr_err               = 1'b0;
        if (!rst) begin
            mem_wd                 = ex_wd;
            mem_wreg               = ex_wreg & ~misaligned & ~kill;
            mem_wdata              = is_load ? load_val : ex_wdata;
            mem_cp0_reg_we         = ex_cp0_reg_we & ~kill;
            mem_cp0_reg_write_addr = ex_cp0_reg_write_addr;
            mem_cp0_reg_data       = ex_cp0_reg_data;
            stallreq               = stallreq_c;
            addr_err               = misaligned;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [5:0]  stall, ext_stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_op;
    logic [31:0] ex_mem_addr, ex_reg2;
    logic        ex_cp0_reg_we;
    logic [4:0]  ex_cp0_reg_write_addr;
    logic [31:0] ex_cp0_reg_data;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_cp0_reg_we;
    logic [4:0]  mem_cp0_reg_write_addr;
    logic [31:0] mem_cp0_reg_data;
    logic        stallreq, addr_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack;

    int n_cmp = 0;
    int n_err = 0;

    // Stall controller stand-in: our own request stops stages 0-4, plus any foreign source.
    assign stall = (stallreq ? 6'b011111 : 6'b000000) | ext_stall;

    mem_access dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_op(ex_op),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_cp0_reg_we(ex_cp0_reg_we), .ex_cp0_reg_write_addr(ex_cp0_reg_write_addr),
        .ex_cp0_reg_data(ex_cp0_reg_data),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
        .mem_cp0_reg_data(mem_cp0_reg_data),
        .stallreq(stallreq), .addr_err(addr_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the big-endian byte numbering.
    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd);
        int unsigned o, b, h;
        o = addr % 4;
        b = (rd >> (8 * (3 - o))) % 256;
        h = (rd >> (16 * (1 - o / 2))) % 65536;
        case (op)
            4'd1:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            4'd2:    return b;
            4'd3:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            4'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
        int unsigned o;
        o = addr % 4;
        case (op)
            4'd1, 4'd2, 4'd9:  return 4'(1 << (3 - o));
            4'd3, 4'd4, 4'd10: return (o == 0) ? 4'hC : 4'h3;
            default:           return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            4'd9:    return (d % 256) * 32'h01010101;
            4'd10:   return (d % 65536) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr(input logic [3:0] op);
        logic [31:0] a;
        a = $urandom;
        if (op == 4'd3 || op == 4'd4 || op == 4'd10) a = a - (a % 2);
        if (op == 4'd5 || op == 4'd11) a = a - (a % 4);
        return a;
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        flush = 0; ext_stall = 0; ex_op = 0; ex_wd = 0; ex_wreg = 0; ex_wdata = 0;
        ex_mem_addr = 0; ex_reg2 = 0; ex_cp0_reg_we = 0; ex_cp0_reg_write_addr = 0;
        ex_cp0_reg_data = 0; bus_rdata = 0; bus_ack = 0;
    endtask

    // One load, ack on the k-th bus cycle counted from the issue cycle (k>=1).
    task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd,
                           input int k, output logic [31:0] got);
        logic [31:0] exp;
        int nst;
        exp = m_load(op, addr, rd);
        ex_op = op; ex_mem_addr = addr; ex_wreg = 1; ex_wd = 5'($urandom); ex_wdata = $urandom;
        bus_ack = 0; bus_rdata = $urandom;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL ld_idle_req got=%b exp=0", bus_req); end
        nst = stallreq ? 1 : 0;
        for (int i = 1; i < k; i++) begin
            tick; bus_rdata = $urandom; #1;
            if (stallreq) nst++;
            n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin n_err++; $display("FAIL ld_busy_req got req=%b we=%b exp req=1 we=0", bus_req, bus_we); end
        end
        tick; bus_ack = 1; bus_rdata = rd; #1;
        if (stallreq) nst++;
        n_cmp++; if (nst !== k) begin n_err++; $display("FAIL ld_stall_cycles got=%0d exp=%0d", nst, k); end
        n_cmp++; if (bus_req !== 1'b1 || bus_addr !== (addr - addr % 4) || bus_sel !== m_sel(op, addr)) begin
            n_err++; $display("FAIL ld_bus got req=%b addr=%h sel=%b exp req=1 addr=%h sel=%b", bus_req, bus_addr, bus_sel, addr - addr % 4, m_sel(op, addr)); end
        n_cmp++; if (mem_wdata !== exp || mem_wreg !== 1'b1) begin
            n_err++; $display("FAIL ld_data op=%0d addr=%h got=%h wreg=%b exp=%h wreg=1", op, addr, mem_wdata, mem_wreg, exp); end
        got = mem_wdata;
        tick; bus_ack = 0; ex_op = 0;
    endtask

    task automatic do_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] d, input int k,
                            output logic [3:0] o_sel, output logic [31:0] o_wd, output logic [31:0] o_ad);
        ex_op = op; ex_mem_addr = addr; ex_reg2 = d; ex_wreg = 0; ex_wdata = $urandom; bus_ack = 0;
        #1;
        n_cmp++; if (stallreq !== 1'b1 || bus_req !== 1'b0) begin n_err++; $display("FAIL st_issue got stallreq=%b req=%b exp 1/0", stallreq, bus_req); end
        for (int i = 1; i <= k; i++) begin
            tick; if (i == k) bus_ack = 1; #1;
            n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_sel !== m_sel(op, addr) || bus_wdata !== m_wdata(op, d)) begin
                n_err++; $display("FAIL st_bus got req=%b we=%b sel=%b wd=%h exp 1/1/%b/%h", bus_req, bus_we, bus_sel, bus_wdata, m_sel(op, addr), m_wdata(op, d)); end
        end
        n_cmp++; if (stallreq !== 1'b0 || mem_wdata !== ex_wdata || mem_wreg !== 1'b0) begin
            n_err++; $display("FAIL st_ack got stallreq=%b wdata=%h wreg=%b exp 0/%h/0", stallreq, mem_wdata, mem_wreg, ex_wdata); end
        o_sel = bus_sel; o_wd = bus_wdata; o_ad = bus_addr;
        tick; bus_ack = 0; ex_op = 0;
    endtask

    task automatic test_reset;
        rst = 1; ex_op = 4'd5; ex_mem_addr = 32'h102; ex_wreg = 1; ex_wd = 5'h1f; ex_cp0_reg_we = 1;
        #1;
        n_cmp++; if (stallreq !== 0 || addr_err !== 0 || mem_wreg !== 0 || mem_wd !== 0 || mem_cp0_reg_we !== 0) begin
            n_err++; $display("FAIL rst_comb got stallreq=%b addr_err=%b wreg=%b wd=%h cp0we=%b exp all 0", stallreq, addr_err, mem_wreg, mem_wd, mem_cp0_reg_we); end
        tick;
        n_cmp++; if (bus_req !== 0 || bus_we !== 0 || bus_sel !== 0 || bus_addr !== 0 || bus_wdata !== 0) begin
            n_err++; $display("FAIL rst_bus got req=%b we=%b sel=%b addr=%h wd=%h exp all 0", bus_req, bus_we, bus_sel, bus_addr, bus_wdata); end
        clear_inputs; rst = 0; tick;
    endtask

    task automatic test_loads;
        logic [31:0] g;
        logic [3:0] ops [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        logic [3:0] op;
        do_load(4'd5, 32'h100, 32'h8899AABB, 3, g);
        n_cmp++; if (g !== 32'h8899AABB) begin n_err++; $display("FAIL lw_const got=%h exp=8899aabb", g); end
        do_load(4'd1, 32'h403, 32'h123456F0, 1, g);
        n_cmp++; if (g !== 32'hFFFFFFF0) begin n_err++; $display("FAIL lb_const got=%h exp=fffffff0", g); end
        do_load(4'd2, 32'h403, 32'h123456F0, 2, g);
        n_cmp++; if (g !== 32'h000000F0) begin n_err++; $display("FAIL lbu_const got=%h exp=000000f0", g); end
        do_load(4'd3, 32'h402, 32'h00008001, 1, g);
        n_cmp++; if (g !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_const got=%h exp=ffff8001", g); end
        for (int i = 0; i < 20; i++) begin
            op = ops[$urandom_range(0, 4)];
            do_load(op, rand_addr(op), $urandom, int'($urandom_range(1, 4)), g);
        end
    endtask

    task automatic test_stores;
        logic [3:0] s; logic [31:0] w, a;
        logic [3:0] ops [3] = '{4'd9, 4'd10, 4'd11};
        logic [3:0] op;
        do_store(4'd9, 32'h201, 32'h123456A5, 2, s, w, a);
        n_cmp++; if (s !== 4'b0100 || w !== 32'hA5A5A5A5 || a !== 32'h200) begin
            n_err++; $display("FAIL sb_const got sel=%b wd=%h addr=%h exp 0100/a5a5a5a5/00000200", s, w, a); end
        do_store(4'd10, 32'h202, 32'h0000BEEF, 3, s, w, a);
        n_cmp++; if (s !== 4'b0011 || w !== 32'hBEEFBEEF || a !== 32'h200) begin
            n_err++; $display("FAIL sh_const got sel=%b wd=%h addr=%h exp 0011/beefbeef/00000200", s, w, a); end
        for (int i = 0; i < 12; i++) begin
            op = ops[$urandom_range(0, 2)];
            do_store(op, rand_addr(op), $urandom, int'($urandom_range(1, 3)), s, w, a);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] g, w, a; logic [3:0] s, op;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                op = 4'($urandom_range(1, 5));
                do_load(op, rand_addr(op), $urandom, 1, g);
            end else begin
                op = 4'($urandom_range(9, 11));
                do_store(op, rand_addr(op), $urandom, 1, s, w, a);
            end
        end
    endtask

    task automatic test_hold;
        logic [3:0] op; logic [31:0] addr, rd, exp, g;
        op = 4'($urandom_range(1, 5)); addr = rand_addr(op); rd = $urandom; exp = m_load(op, addr, rd);
        ex_op = op; ex_mem_addr = addr; ex_wreg = 1; #1;
        tick; bus_ack = 1; bus_rdata = rd; ext_stall = 6'b111111; #1;
        n_cmp++; if (mem_wdata !== exp) begin n_err++; $display("FAIL hold_ack got=%h exp=%h", mem_wdata, exp); end
        for (int i = 0; i < 3; i++) begin
            tick; bus_ack = 0; bus_rdata = ~rd; if (i == 2) ext_stall = 0; #1;
            n_cmp++; if (bus_req !== 0 || stallreq !== 0 || mem_wdata !== exp) begin
                n_err++; $display("FAIL hold_cyc%0d got req=%b stallreq=%b wdata=%h exp 0/0/%h", i, bus_req, stallreq, mem_wdata, exp); end
        end
        tick; ex_op = 0;
        // A fresh load must issue immediately, which only IDLE does.
        do_load(4'd5, 32'h500, 32'hCAFEF00D, 1, g);
    endtask

    task automatic test_flush;
        logic [31:0] w, a; logic [3:0] s;
        ex_op = 4'd5; ex_mem_addr = 32'h100; ex_wreg = 1; ex_cp0_reg_we = 1; #1;
        tick; flush = 1; #1;
        n_cmp++; if (bus_req !== 1 || mem_wreg !== 0 || mem_cp0_reg_we !== 0) begin
            n_err++; $display("FAIL flush_busy got req=%b wreg=%b cp0we=%b exp 1/0/0", bus_req, mem_wreg, mem_cp0_reg_we); end
        tick; flush = 0; ex_op = 0; #1;
        n_cmp++; if (bus_req !== 1 || stallreq !== 0 || mem_wreg !== 0 || mem_cp0_reg_we !== 0) begin
            n_err++; $display("FAIL drain1 got req=%b stallreq=%b wreg=%b cp0we=%b exp 1/0/0/0", bus_req, stallreq, mem_wreg, mem_cp0_reg_we); end
        tick; ex_op = 4'd11; ex_mem_addr = 32'h300; ex_reg2 = 32'h11223344; ex_wreg = 0; bus_ack = 1; #1;
        n_cmp++; if (bus_req !== 1 || stallreq !== 1 || mem_cp0_reg_we !== 0) begin
            n_err++; $display("FAIL drain2 got req=%b stallreq=%b cp0we=%b exp 1/1/0", bus_req, stallreq, mem_cp0_reg_we); end
        tick; bus_ack = 0; ex_cp0_reg_we = 0; #1;
        n_cmp++; if (bus_req !== 0 || stallreq !== 1) begin
            n_err++; $display("FAIL drain_exit got req=%b stallreq=%b exp 0/1", bus_req, stallreq); end
        do_store(4'd11, 32'h300, 32'h11223344, 1, s, w, a);
        n_cmp++; if (a !== 32'h300 || w !== 32'h11223344) begin
            n_err++; $display("FAIL post_drain_st got addr=%h wd=%h exp 00000300/11223344", a, w); end
    endtask

    task automatic test_misaligned;
        logic [3:0] ops [5] = '{4'd3, 4'd4, 4'd10, 4'd5, 4'd11};
        ex_op = 4'd5; ex_mem_addr = 32'h102; ex_wreg = 1; #1;
        n_cmp++; if (addr_err !== 1 || stallreq !== 0 || mem_wreg !== 0) begin
            n_err++; $display("FAIL lw_102 got err=%b stallreq=%b wreg=%b exp 1/0/0", addr_err, stallreq, mem_wreg); end
        tick;
        n_cmp++; if (bus_req !== 0) begin n_err++; $display("FAIL lw_102_req got=%b exp=0", bus_req); end
        for (int i = 0; i < 8; i++) begin
            ex_op = ops[$urandom_range(0, 4)];
            ex_mem_addr = $urandom;
            if (ex_op == 4'd5 || ex_op == 4'd11) begin
                if (ex_mem_addr % 4 == 0) ex_mem_addr = ex_mem_addr + 32'($urandom_range(1, 3));
            end else if (ex_mem_addr % 2 == 0) ex_mem_addr = ex_mem_addr + 1;
            #1;
            n_cmp++; if (addr_err !== 1 || stallreq !== 0 || mem_wreg !== 0) begin
                n_err++; $display("FAIL misal op=%0d addr=%h got err=%b stallreq=%b wreg=%b exp 1/0/0", ex_op, ex_mem_addr, addr_err, stallreq, mem_wreg); end
            tick;
            n_cmp++; if (bus_req !== 0) begin n_err++; $display("FAIL misal_req got=%b exp=0", bus_req); end
        end
        ex_op = 0;
    endtask

    task automatic test_rst_mid;
        logic [31:0] g;
        ex_op = 4'd5; ex_mem_addr = 32'h700; ex_wreg = 1; #1;
        tick; rst = 1; #1;
        n_cmp++; if (stallreq !== 0 || mem_wreg !== 0) begin
            n_err++; $display("FAIL rst_mid_comb got stallreq=%b wreg=%b exp 0/0", stallreq, mem_wreg); end
        tick; rst = 0; ex_op = 0; #1;
        n_cmp++; if (bus_req !== 0) begin n_err++; $display("FAIL rst_mid_req got=%b exp=0", bus_req); end
        do_load(4'd4, 32'h702, 32'h1234ABCD, 2, g);
        n_cmp++; if (g !== 32'h0000ABCD) begin n_err++; $display("FAIL lhu_after_rst got=%h exp=0000abcd", g); end
    endtask

    task automatic test_nonmem;
        logic [3:0] ops [8] = '{4'd0, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};
        for (int i = 0; i < 8; i++) begin
            ex_op = ops[i]; ex_mem_addr = $urandom; ex_wdata = $urandom; ex_wreg = 1'($urandom);
            ex_wd = 5'($urandom); ex_cp0_reg_we = 1'($urandom); ex_cp0_reg_write_addr = 5'($urandom);
            ex_cp0_reg_data = $urandom;
            #1;
            n_cmp++; if (stallreq !== 0 || addr_err !== 0 || mem_wdata !== ex_wdata || mem_wreg !== ex_wreg || mem_wd !== ex_wd) begin
                n_err++; $display("FAIL nonmem op=%0d got stallreq=%b err=%b wdata=%h wreg=%b wd=%h exp 0/0/%h/%b/%h",
                                  ex_op, stallreq, addr_err, mem_wdata, mem_wreg, mem_wd, ex_wdata, ex_wreg, ex_wd); end
            n_cmp++; if (mem_cp0_reg_we !== ex_cp0_reg_we || mem_cp0_reg_write_addr !== ex_cp0_reg_write_addr || mem_cp0_reg_data !== ex_cp0_reg_data) begin
                n_err++; $display("FAIL cp0_pass got we=%b a=%h d=%h exp %b/%h/%h", mem_cp0_reg_we, mem_cp0_reg_write_addr,
                                  mem_cp0_reg_data, ex_cp0_reg_we, ex_cp0_reg_write_addr, ex_cp0_reg_data); end
            tick;
            n_cmp++; if (bus_req !== 0) begin n_err++; $display("FAIL nonmem_req got=%b exp=0", bus_req); end
        end
        clear_inputs;
    endtask

    initial begin
        clear_inputs;
        test_reset;
        test_loads;
        test_stores;
        test_back_to_back;
        test_hold;
        test_flush;
        test_misaligned;
        test_rst_mid;
        test_nonmem;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
